// File: rtl/bist_scheduler.sv
// Sequences per-core BIST controllers one at a time: launch, wait for the end
// edge or watchdog expiry, record pass/fail, then move to the next enabled core.
module bist_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT   = 8191,
  localparam int SEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sched_start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_bist_end,
  input  logic [NUM_CORES-1:0] core_pass,
  output logic [NUM_CORES-1:0] core_bist_start,
  output logic [SEL_W-1:0]     core_sel,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CORES-1:0] fail_vec,
  output logic [NUM_CORES-1:0] timeout_vec
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CORES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RECORD = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [SEL_W-1:0]     idx, idx_n;
  logic [WD_W-1:0]      wd, wd_n;
  logic [NUM_CORES-1:0] mask_q, mask_n;
  logic                 pass_q, pass_n;
  logic [NUM_CORES-1:0] fail_n, timeout_n;
  logic                 start_prev, end_prev;
  logic                 start_edge, end_edge;

  assign start_edge = sched_start & ~start_prev;
  assign end_edge   = core_bist_end[idx] & ~end_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      wd          <= '0;
      mask_q      <= '0;
      pass_q      <= 1'b0;
      fail_vec    <= '0;
      timeout_vec <= '0;
      start_prev  <= 1'b0;
      end_prev    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      wd          <= wd_n;
      mask_q      <= mask_n;
      pass_q      <= pass_n;
      fail_vec    <= fail_n;
      timeout_vec <= timeout_n;
      start_prev  <= sched_start;
      // Tracks the currently indexed core, so an end level already high at
      // launch is seen as "previous high" and cannot fake a completion.
      end_prev    <= core_bist_end[idx];
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wd_n      = wd;
    mask_n    = mask_q;
    pass_n    = pass_q;
    fail_n    = fail_vec;
    timeout_n = timeout_vec;
    unique case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          mask_n    = core_mask;
          fail_n    = '0;
          timeout_n = '0;
          idx_n     = '0;
          state_n   = SELECT;
        end
      end
      SELECT: begin
        if (mask_q[idx]) begin
          state_n = LAUNCH;
        end else if (idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n = idx + SEL_W'(1);
        end
      end
      LAUNCH: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (wd != WD_MAX) begin
          wd_n = wd + WD_W'(1);
        end
        // End edge takes priority over an expiring watchdog in the same cycle.
        if (end_edge) begin
          pass_n  = core_pass[idx];
          state_n = RECORD;
        end else if (wd == WD_MAX) begin
          timeout_n[idx] = 1'b1;
          pass_n         = 1'b0;
          state_n        = RECORD;
        end
      end
      RECORD: begin
        fail_n[idx] = ~pass_q;
        if (idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + SEL_W'(1);
          state_n = SELECT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    core_bist_start = '0;
    if (state == LAUNCH) begin
      core_bist_start[idx] = 1'b1;
    end
  end

  assign core_sel = idx;
  assign busy     = (state == SELECT) || (state == LAUNCH) ||
                    (state == WAIT)   || (state == RECORD);
  assign done     = (state == DONE);

endmodule

// File: doc/bist_scheduler.md
BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 The module SHALL have a parameter NUM_CORES, default 4, giving the number of per-core BIST controllers it sequences (range 2..16).
REQ-002 The module SHALL have a parameter TIMEOUT, default 8191, giving the maximum number of WAIT cycles per core before the watchdog fires.
REQ-003 The module SHALL have a derived parameter SEL_W = max(1, clog2(NUM_CORES)), the width of the core index.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 sched_start  in  1  session request; acted on at its rising edge only.
REQ-007 core_mask  in  NUM_CORES  per-core enable, sampled at session accept.
REQ-008 core_bist_end  in  NUM_CORES  per-core end-of-BIST level from each controller.
REQ-009 core_pass  in  NUM_CORES  per-core signature-compare result, valid with core_bist_end.
REQ-010 core_bist_start  out  NUM_CORES  one-hot, one-cycle start pulse to the selected controller.
REQ-011 core_sel  out  SEL_W  index of the core currently being tested.
REQ-012 busy  out  1  high while a session is in progress.
REQ-013 done  out  1  high, as a level, after a session completes and until the next accept.
REQ-014 fail_vec  out  NUM_CORES  per-core fail flag: signature mismatch or timeout.
REQ-015 timeout_vec  out  NUM_CORES  per-core watchdog-expired flag.

Function
REQ-016 The FSM SHALL have states IDLE, SELECT, LAUNCH, WAIT, RECORD and DONE, all registered; unused encodings SHALL go to IDLE.
REQ-017 Rising edges of sched_start and of core_bist_end[core_sel] SHALL be detected against a registered copy of the previous-cycle value.
REQ-018 A start edge SHALL be accepted only in IDLE or DONE, and ignored in all other states.
REQ-019 On accept, the block SHALL latch core_mask into mask_q, clear fail_vec, timeout_vec and done, set the index to 0, and enter SELECT at the next edge.
REQ-020 In SELECT: if mask_q[idx]=1 the block SHALL go to LAUNCH; else if idx=NUM_CORES-1 it SHALL go to DONE; else it SHALL increment idx and stay in SELECT; each skipped core costs 1 cycle.
REQ-021 In LAUNCH, core_bist_start[idx] SHALL be 1 for exactly one cycle, the watchdog SHALL clear to 0, and the next state SHALL be WAIT.
REQ-022 In WAIT, the watchdog SHALL increment by 1 each cycle and saturate at TIMEOUT; its width SHALL be clog2(TIMEOUT+1).
REQ-023 In WAIT, a rising edge of core_bist_end[idx] SHALL capture core_pass[idx] into pass_q in the same cycle and move to RECORD.
REQ-024 In WAIT, a watchdog value of TIMEOUT with no edge SHALL set timeout_vec[idx], clear pass_q, and move to RECORD.
REQ-025 If the end edge and the timeout occur in the same cycle, the end edge SHALL win and timeout_vec[idx] SHALL stay 0.
REQ-026 A core_bist_end level already high at LAUNCH SHALL NOT count as completion; only a rising edge counts.
REQ-027 In RECORD, the block SHALL set fail_vec[idx] = ~pass_q; then, if idx=NUM_CORES-1, go to DONE, else increment idx and go to SELECT.
REQ-028 busy SHALL be 1 in SELECT, LAUNCH, WAIT and RECORD, and 0 otherwise.
REQ-029 done SHALL be 1 only in DONE.
REQ-030 core_sel SHALL equal idx while busy, and hold its last value in DONE.
REQ-031 fail_vec and timeout_vec SHALL hold their values in DONE until the next accept.
REQ-032 Changes to core_mask during a session SHALL have no effect.
REQ-033 An all-zero mask SHALL reach DONE after NUM_CORES SELECT cycles, with fail_vec=0 and no start pulse issued.
REQ-034 At most one bit of core_bist_start SHALL be high in any cycle.

Reset
REQ-035 Asserting reset (0) SHALL immediately force, without waiting for a clock edge: state=IDLE, idx=0, watchdog=0, core_bist_start=0, core_sel=0, busy=0, done=0, fail_vec=0, timeout_vec=0, mask_q=0, pass_q=0, and both edge-detect registers to 0.
REQ-036 Reset asserted mid-session SHALL abort the session with no further start pulse issued.
REQ-037 A sched_start held high across reset deassertion SHALL count as an edge on the first clock after deassertion.

Verification
REQ-038 NUM_CORES=4, mask=4'b1111, every core raises end 20 cycles after its start with pass=1 -> four single start pulses in core order 0,1,2,3; done=1; fail_vec=0000; timeout_vec=0000.
REQ-039 mask=4'b0101, core 2 returns pass=0 -> pulses on cores 0 and 2 only; fail_vec=0100; cores 1 and 3 each skipped in 1 cycle.
REQ-040 TIMEOUT=15, core 1 never raises end -> core 1 leaves WAIT after 15 cycles; fail_vec=0010; timeout_vec=0010; core 2 is then launched.
REQ-041 core_bist_end[0] held high before launch and after it -> no completion is recorded until end goes low and rises again; a start edge during WAIT is ignored.
REQ-042 mask=0000 -> done after 4 SELECT cycles with no pulses; reset=0 asserted during WAIT of core 1 -> all outputs 0 immediately, state IDLE.
